uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Lets NUM_REQ byte-stream requesters share one UART transmitter. Grants are
// round-robin, and a grant lasts for one packet or BURST_MAX bytes, whichever
// ends first. Each grant is registered one cycle after the request is seen.
// While a grant is held, the owner's stream passes through combinationally,
// so the data path adds no latency.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   enable         1 = new grants permitted (a grant in progress always completes)
//   req_tdata      per-requester byte, requester i at [8i+7:8i]
//   req_tvalid     per-requester byte valid
//   req_tlast      per-requester end-of-packet marker
//   req_tready     per-requester accept (only the owner's bit can be high)
//   m_axis_tdata   byte to the UART TX stream
//   m_axis_tvalid  byte valid to the UART
//   m_axis_tready  UART accept
//   grant_valid    high while a requester owns the UART
//   grant_id       index of the owner, meaningful only with grant_valid
//   beat_count     bytes accepted in the current grant
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned GW        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_REQ*8-1:0] req_tdata,
  input  logic [NUM_REQ-1:0]   req_tvalid,
  input  logic [NUM_REQ-1:0]   req_tlast,
  output logic [NUM_REQ-1:0]   req_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 grant_valid,
  output logic [GW-1:0]        grant_id,
  output logic [7:0]           beat_count
);

  localparam int unsigned   BW        = 8;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
  localparam logic [GW-1:0] GID_LAST  = GW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        state;
  logic [GW-1:0] last_grant;

  logic          in_xfer_c;
  logic          beat_c;
  logic          exit_c;
  logic          arb_found_c;
  logic [GW-1:0] arb_sel_c;

  // Round-robin pick: first valid requester after last_grant, wrapping at NUM_REQ.
  always_comb begin
    int unsigned idx;
    arb_found_c = 1'b0;
    arb_sel_c   = '0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant) + k) % NUM_REQ;
      if (!arb_found_c && req_tvalid[GW'(idx)]) begin
        arb_found_c = 1'b1;
        arb_sel_c   = GW'(idx);
      end
    end
  end

  // The pass-through is blanked during the reset cycle. Otherwise a packet
  // being abandoned could still complete a beat while rst is high.
  assign in_xfer_c = (state == XFER) && !rst;

  // Owner's byte mux.
  always_comb begin
    m_axis_tdata = '0;
    if (in_xfer_c) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id == GW'(i)) begin
          m_axis_tdata = req_tdata[8*i +: 8];
        end
      end
    end
  end

  assign m_axis_tvalid = in_xfer_c && req_tvalid[grant_id];

  // Only the owner sees the UART's ready; everyone else stalls.
  always_comb begin
    req_tready = '0;
    if (in_xfer_c) begin
      req_tready[grant_id] = m_axis_tready;
    end
  end

  assign beat_c = m_axis_tvalid && m_axis_tready;

  // A tlast beat that is also the BURST_MAX-th beat gives a single exit.
  assign exit_c = beat_c && (req_tlast[grant_id] || (beat_count == BEAT_LAST));

  // Grant state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      beat_count  <= '0;
      last_grant  <= GID_LAST;
    end else begin
      case (state)
        IDLE: begin
          if (enable && arb_found_c) begin
            state       <= XFER;
            grant_valid <= 1'b1;
            grant_id    <= arb_sel_c;
            beat_count  <= '0;
          end
        end
        XFER: begin
          // An owner that drops tvalid keeps the grant. Nothing times out.
          if (beat_c) begin
            beat_count <= beat_count + BW'(1);
            if (exit_c) begin
              state       <= IDLE;
              grant_valid <= 1'b0;
              last_grant  <= grant_id;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned BURST_MAX = 16;
  localparam int unsigned GW        = 2;
  localparam int unsigned DEPTH     = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic [NUM_REQ*8-1:0] req_tdata;
  logic [NUM_REQ-1:0]   req_tvalid;
  logic [NUM_REQ-1:0]   req_tlast;
  logic [NUM_REQ-1:0]   req_tready;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 grant_valid;
  logic [GW-1:0]        grant_id;
  logic [7:0]           beat_count;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BURST_MAX(BURST_MAX), .GW(GW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tlast(req_tlast),
    .req_tready(req_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .grant_valid(grant_valid), .grant_id(grant_id), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: which requester, which byte, beat index within the grant.
  typedef struct packed {
    logic [GW-1:0] id;
    logic [7:0]    data;
    logic [7:0]    bc;
  } exp_t;

  // Per-cycle vector: inputs enable/mready, expected control outputs.
  typedef struct packed {
    logic          en;
    logic          mready;
    logic          gv;
    logic [GW-1:0] gid;
    logic          mvalid;
  } vec_t;

  exp_t         exp_q[$];
  int           beat_cyc[$];
  vec_t         vecs[11];
  logic [7:0]   src_d[NUM_REQ][DEPTH];
  logic         src_l[NUM_REQ][DEPTH];
  int           head[NUM_REQ];
  int           tail[NUM_REQ];
  logic [NUM_REQ-1:0] acc;
  int           cyc;
  int           n_chk;
  int           n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic push_src(input int r, input logic [7:0] d, input logic l);
    src_d[r][tail[r]] = d;
    src_l[r][tail[r]] = l;
    tail[r]++;
  endtask

  task automatic push_exp(input int r, input logic [7:0] d, input logic [7:0] bc);
    exp_t e;
    e.id   = GW'(r);
    e.data = d;
    e.bc   = bc;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head[i] < tail[i]) begin
        req_tvalid[i]         = 1'b1;
        req_tdata[8*i +: 8]   = src_d[i][head[i]];
        req_tlast[i]          = src_l[i][head[i]];
      end else begin
        req_tvalid[i]         = 1'b0;
        req_tdata[8*i +: 8]   = 8'h00;
        req_tlast[i]          = 1'b0;
      end
    end
  endtask

  // Negedge monitor: score beats, check stalled data stays put.
  task automatic at_neg();
    exp_t e;
    @(negedge clk);
    acc = req_tvalid & req_tready;
    if (acc != '0) chk("tready_owner", 32'(acc), 32'(1) << grant_id);
    if (m_axis_tvalid && m_axis_tready) begin
      beat_cyc.push_back(cyc);
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat (cycle %0d)",
                 grant_id, m_axis_tdata, cyc);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        chk("beat_id", 32'(grant_id), 32'(e.id));
        chk("beat_data", 32'(m_axis_tdata), 32'(e.data));
        chk("beat_count", 32'(beat_count), 32'(e.bc));
        chk("beat_gv", 32'(grant_valid), 32'd1);
      end
    end else if (m_axis_tvalid && !m_axis_tready && exp_q.size() != 0) begin
      chk("hold_data", 32'(m_axis_tdata), 32'(exp_q[0].data));
    end
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) head[i]++;
    acc = '0;
    drive();
  endtask

  task automatic run_drain(input int budget, input bit toggle);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      m_axis_tready = toggle ? ((k % 2) == 0) : 1'b1;
      at_neg();
      at_pos();
      k++;
    end
    m_axis_tready = 1'b1;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    else n_pass++;
  endtask

  // One reset cycle, then check that every output holds its reset value.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    at_neg();
    chk({tag, "_rstcyc_mvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_rstcyc_tready"}, 32'(req_tready), 32'd0);
    at_pos();
    rst = 1'b0;
    at_neg();
    chk({tag, "_gv"}, 32'(grant_valid), 32'd0);
    chk({tag, "_gid"}, 32'(grant_id), 32'd0);
    chk({tag, "_bc"}, 32'(beat_count), 32'd0);
    chk({tag, "_mvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tready"}, 32'(req_tready), 32'd0);
    at_pos();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; acc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin head[i] = 0; tail[i] = 0; end
    rst = 1'b1; enable = 1'b0; m_axis_tready = 1'b1;
    req_tdata = '0; req_tvalid = '0; req_tlast = '0;
    drive();

    // Reset from power-up.
    at_neg();
    at_pos();
    at_neg();
    chk("por_gv", 32'(grant_valid), 32'd0);
    chk("por_gid", 32'(grant_id), 32'd0);
    chk("por_bc", 32'(beat_count), 32'd0);
    chk("por_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("por_tready", 32'(req_tready), 32'd0);
    at_pos();
    rst = 1'b0;

    // All four requesters send one-byte packets, and requester 0 sends a second one.
    // Expected grant order is 0,1,2,3,0 with an idle cycle between grants.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    for (int r = 0; r < NUM_REQ; r++) push_src(r, 8'(8'h10 + r), 1'b1);
    push_src(0, 8'h50, 1'b1);
    for (int r = 0; r < NUM_REQ; r++) push_exp(r, 8'(8'h10 + r), 8'd0);
    push_exp(0, 8'h50, 8'd0);
    drive();
    for (int v = 0; v < 11; v++) begin
      enable        = vecs[v].en;
      m_axis_tready = vecs[v].mready;
      at_neg();
      chk($sformatf("rr_v%0d_gv", v), 32'(grant_valid), 32'(vecs[v].gv));
      chk($sformatf("rr_v%0d_mvalid", v), 32'(m_axis_tvalid), 32'(vecs[v].mvalid));
      if (vecs[v].gv) chk($sformatf("rr_v%0d_gid", v), 32'(grant_id), 32'(vecs[v].gid));
      at_pos();
    end
    chk("rr_all_served", 32'(exp_q.size()), 32'd0);

    // Five-byte packet from requester 2 while requester 0 waits.
    beat_cyc.delete();
    for (int b = 0; b < 5; b++) begin
      push_src(2, 8'(8'hA0 + b), b == 4);
      push_exp(2, 8'(8'hA0 + b), 8'(b));
    end
    push_src(0, 8'hB0, 1'b0); push_src(0, 8'hB1, 1'b1);
    push_exp(0, 8'hB0, 8'd0); push_exp(0, 8'hB1, 8'd1);
    drive();
    run_drain(40, 1'b0);
    if (beat_cyc.size() >= 5) chk("pkt_contiguous", 32'(beat_cyc[4] - beat_cyc[0]), 32'd4);
    else chk("pkt_beats", 32'(beat_cyc.size()), 32'd5);

    // Forty bytes from requester 1 with no tlast: split as 16, 16 and 8.
    for (int b = 0; b < 40; b++) begin
      push_src(1, 8'(b), 1'b0);
      push_exp(1, 8'(b), 8'(b % 16));
    end
    drive();
    run_drain(200, 1'b0);
    // The owner has nothing more to send, so the grant is held and the count frozen.
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("stall_gv", 32'(grant_valid), 32'd1);
      chk("stall_gid", 32'(grant_id), 32'd1);
      chk("stall_bc", 32'(beat_count), 32'd8);
      chk("stall_mvalid", 32'(m_axis_tvalid), 32'd0);
      at_pos();
    end
    do_reset("rst1");

    // Reset after two beats abandons the packet. Requester 0 still wins first.
    for (int b = 0; b < 4; b++) push_src(0, 8'(8'hC0 + b), b == 3);
    push_src(2, 8'hD0, 1'b1);
    push_exp(0, 8'hC0, 8'd0); push_exp(0, 8'hC1, 8'd1);
    drive();
    run_drain(20, 1'b0);
    do_reset("rst2");
    push_exp(0, 8'hC2, 8'd0); push_exp(0, 8'hC3, 8'd1); push_exp(2, 8'hD0, 8'd0);
    run_drain(20, 1'b0);

    // Three-byte packet from requester 1 with the UART stalling every other cycle.
    for (int b = 0; b < 3; b++) begin
      push_src(1, 8'(8'hE0 + b), b == 2);
      push_exp(1, 8'(8'hE0 + b), 8'(b));
    end
    drive();
    run_drain(40, 1'b1);

    // With enable low, requester 3's request is not granted. Raising enable
    // grants it one cycle later.
    enable = 1'b0;
    push_src(3, 8'hF0, 1'b1);
    push_exp(3, 8'hF0, 8'd0);
    drive();
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("en_off_gv", 32'(grant_valid), 32'd0);
      at_pos();
    end
    enable = 1'b1;
    at_neg();
    chk("en_on_gv0", 32'(grant_valid), 32'd0);
    at_pos();
    at_neg();
    chk("en_on_gv1", 32'(grant_valid), 32'd1);
    chk("en_on_gid", 32'(grant_id), 32'd3);
    at_pos();
    chk("en_served", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
